// File: rtl/rail_crossing_sequencer.sv
// Level-crossing sequencer for one road crossed by two tracks: round-robin train
// arbitration, timed warning/gate/clearance phases and a minimum road-green hold.
module rail_crossing_sequencer #(
  parameter int YELLOW_CYC   = 3,
  parameter int GATE_CYC     = 4,
  parameter int CLEAR_CYC    = 2,
  parameter int MIN_ROAD_CYC = 5,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] train,
  output logic [1:0] road,
  output logic [1:0] track0,
  output logic [1:0] track1,
  output logic       gate_down,
  output logic [1:0] grant
);

  typedef enum logic [2:0] {
    S_ROAD_GO     = 3'd0,
    S_ROAD_WARN   = 3'd1,
    S_GATE_LOWER  = 3'd2,
    S_TRACK_GO    = 3'd3,
    S_TRACK_CLEAR = 3'd4,
    S_GATE_RAISE  = 3'd5
  } state_e;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_GREEN  = 2'd2;

  localparam logic [CW-1:0] YEL_LOAD  = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] CLR_LOAD  = CW'(CLEAR_CYC - 1);
  localparam logic [CW-1:0] ROAD_LOAD = CW'(MIN_ROAD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gsel_q, gsel_d;
  logic          last_q, last_d;
  logic [1:0]    road_q, road_d;
  logic [1:0]    track0_q, track0_d;
  logic [1:0]    track1_q, track1_d;
  logic          gate_q, gate_d;
  logic [1:0]    grant_q, grant_d;
  logic          cnt_done_s;
  logic [CW-1:0] cnt_dec_s;

  assign cnt_done_s = (cnt_q == CNT_ZERO);
  assign cnt_dec_s  = cnt_done_s ? CNT_ZERO : (cnt_q - CNT_ONE);

  // Next-state, timer and arbitration logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gsel_d  = gsel_q;
    last_d  = last_q;
    case (state_q)
      S_ROAD_GO: begin
        if (!cnt_done_s) begin
          cnt_d = cnt_dec_s;
        end else if (train != 2'b00) begin
          state_d = S_ROAD_WARN;
          cnt_d   = YEL_LOAD;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      S_ROAD_WARN: begin
        if (cnt_done_s) begin
          state_d = S_GATE_LOWER;
          cnt_d   = GATE_LOAD;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_GATE_LOWER: begin
        if (cnt_done_s) begin
          case (train)
            2'b01: begin
              state_d = S_TRACK_GO;
              gsel_d  = 1'b0;
            end
            2'b10: begin
              state_d = S_TRACK_GO;
              gsel_d  = 1'b1;
            end
            2'b11: begin
              state_d = S_TRACK_GO;
              gsel_d  = ~last_q;
            end
            default: begin
              state_d = S_GATE_RAISE;
              cnt_d   = GATE_LOAD;
            end
          endcase
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_TRACK_GO: begin
        if (!train[gsel_q]) begin
          state_d = S_TRACK_CLEAR;
          cnt_d   = CLR_LOAD;
        end else begin
          state_d = S_TRACK_GO;
        end
      end
      S_TRACK_CLEAR: begin
        if (cnt_done_s) begin
          last_d = gsel_q;
          // Waiting train on the other track is handed over with the gate kept down.
          if (train[~gsel_q]) begin
            state_d = S_TRACK_GO;
            gsel_d  = ~gsel_q;
          end else begin
            state_d = S_GATE_RAISE;
            cnt_d   = GATE_LOAD;
          end
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_GATE_RAISE: begin
        if (cnt_done_s) begin
          state_d = S_ROAD_GO;
          cnt_d   = ROAD_LOAD;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      default: begin
        state_d = S_ROAD_GO;
        cnt_d   = CNT_ZERO;
        gsel_d  = 1'b0;
        last_d  = 1'b1;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register
  always_comb begin
    road_d   = L_RED;
    track0_d = L_RED;
    track1_d = L_RED;
    gate_d   = 1'b0;
    grant_d  = 2'b00;
    case (state_d)
      S_ROAD_GO:    road_d = L_GREEN;
      S_ROAD_WARN:  road_d = L_YELLOW;
      S_GATE_LOWER: gate_d = 1'b1;
      S_TRACK_GO: begin
        gate_d  = 1'b1;
        grant_d = gsel_d ? 2'b10 : 2'b01;
        if (gsel_d) begin
          track1_d = L_GREEN;
        end else begin
          track0_d = L_GREEN;
        end
      end
      S_TRACK_CLEAR: begin
        gate_d  = 1'b1;
        grant_d = gsel_d ? 2'b10 : 2'b01;
        if (gsel_d) begin
          track1_d = L_YELLOW;
        end else begin
          track0_d = L_YELLOW;
        end
      end
      S_GATE_RAISE: gate_d = 1'b0;
      default:      road_d = L_GREEN;
    endcase
  end

  // State, timer and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_ROAD_GO;
      cnt_q    <= CNT_ZERO;
      gsel_q   <= 1'b0;
      last_q   <= 1'b1;
      road_q   <= L_GREEN;
      track0_q <= L_RED;
      track1_q <= L_RED;
      gate_q   <= 1'b0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gsel_q   <= gsel_d;
      last_q   <= last_d;
      road_q   <= road_d;
      track0_q <= track0_d;
      track1_q <= track1_d;
      gate_q   <= gate_d;
      grant_q  <= grant_d;
    end
  end

  assign road      = road_q;
  assign track0    = track0_q;
  assign track1    = track1_q;
  assign gate_down = gate_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_rail_crossing_sequencer.sv
// Directed scoreboard checks of the crossing sequence, then random trains with
// safety-invariant and service-latency checks.
module tb_rail_crossing_sequencer;

  logic       clk;
  logic       clr;
  logic [1:0] train;
  logic [1:0] road;
  logic [1:0] track0;
  logic [1:0] track1;
  logic       gate_down;
  logic [1:0] grant;

  int checks   = 0;
  int failures = 0;

  rail_crossing_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .train     (train),
    .road      (road),
    .track0    (track0),
    .track1    (track1),
    .gate_down (gate_down),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {road, track0, track1, gate_down, grant}
  localparam logic [8:0] IDLE  = {2'd2, 2'd0, 2'd0, 1'b0, 2'b00};
  localparam logic [8:0] WARN  = {2'd1, 2'd0, 2'd0, 1'b0, 2'b00};
  localparam logic [8:0] LOWER = {2'd0, 2'd0, 2'd0, 1'b1, 2'b00};
  localparam logic [8:0] RAISE = {2'd0, 2'd0, 2'd0, 1'b0, 2'b00};
  localparam logic [8:0] GO0   = {2'd0, 2'd2, 2'd0, 1'b1, 2'b01};
  localparam logic [8:0] CLR0  = {2'd0, 2'd1, 2'd0, 1'b1, 2'b01};
  localparam logic [8:0] GO1   = {2'd0, 2'd0, 2'd2, 1'b1, 2'b10};
  localparam logic [8:0] CLR1  = {2'd0, 2'd0, 2'd1, 1'b1, 2'b10};
  localparam int WAIT_BOUND = 200;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  logic [8:0] obs_s;
  assign obs_s = {road, track0, track1, gate_down, grant};

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] t, input logic c, input logic [8:0] exp,
                      input string tag, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      train = t;
      clr   = c;
      e.v   = exp;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.tag, obs_s, e.v);
    end
  endtask

  logic [1:0] tr;
  logic [1:0] served;
  int         wait_c [2];
  int         services;

  initial begin
    train = 2'b00;
    clr   = 1'b1;
    step(2'b00, 1'b1, IDLE, "reset", 1);
    step(2'b00, 1'b0, IDLE, "idle", 20);
    // single train on track 0
    step(2'b01, 1'b0, WARN,  "s_warn", 3);
    step(2'b01, 1'b0, LOWER, "s_lower", 4);
    step(2'b01, 1'b0, GO0,   "s_go0", 3);
    step(2'b00, 1'b0, CLR0,  "s_clear0", 2);
    step(2'b00, 1'b0, RAISE, "s_raise", 4);
    step(2'b00, 1'b0, IDLE,  "s_road", 1);
    // request during the minimum road-green hold
    step(2'b10, 1'b0, IDLE,  "hold", 4);
    step(2'b10, 1'b0, WARN,  "hold_warn", 3);
    step(2'b10, 1'b0, LOWER, "t1_lower", 4);
    step(2'b10, 1'b0, GO1,   "t1_go", 2);
    // clear in the middle of TRACK_GO, train still present
    step(2'b10, 1'b1, IDLE,  "clr_mid", 1);
    step(2'b10, 1'b0, WARN,  "clr_restart", 1);
    // both tracks from reset: track 0 first, then handoff without re-warning
    step(2'b00, 1'b1, IDLE,  "reset2", 1);
    step(2'b11, 1'b0, WARN,  "both_warn", 3);
    step(2'b11, 1'b0, LOWER, "both_lower", 4);
    step(2'b11, 1'b0, GO0,   "both_go0", 3);
    step(2'b10, 1'b0, CLR0,  "handoff_clear0", 2);
    step(2'b10, 1'b0, GO1,   "handoff_go1", 3);
    step(2'b00, 1'b0, CLR1,  "handoff_clear1", 2);
    step(2'b00, 1'b0, RAISE, "handoff_raise", 4);
    step(2'b00, 1'b0, IDLE,  "handoff_road", 5);
    // train vanishes before the gate is down
    step(2'b01, 1'b0, WARN,  "vanish_warn", 1);
    step(2'b00, 1'b0, WARN,  "vanish_warn2", 2);
    step(2'b00, 1'b0, LOWER, "vanish_lower", 4);
    step(2'b00, 1'b0, RAISE, "vanish_raise", 4);
    step(2'b00, 1'b0, IDLE,  "vanish_road", 5);
    // serve track 0 alone, then a tie must go to track 1
    step(2'b01, 1'b0, WARN,  "rr_warn", 3);
    step(2'b01, 1'b0, LOWER, "rr_lower", 4);
    step(2'b01, 1'b0, GO0,   "rr_go0", 1);
    step(2'b00, 1'b0, CLR0,  "rr_clear0", 2);
    step(2'b00, 1'b0, RAISE, "rr_raise", 4);
    step(2'b00, 1'b0, IDLE,  "rr_road", 5);
    step(2'b11, 1'b0, WARN,  "tie_warn", 3);
    step(2'b11, 1'b0, LOWER, "tie_lower", 4);
    step(2'b11, 1'b0, GO1,   "tie_go1", 1);
    step(2'b00, 1'b0, CLR1,  "tie_clear1", 2);
    step(2'b00, 1'b0, RAISE, "tie_raise", 4);
    step(2'b00, 1'b0, IDLE,  "tie_road", 1);

    // random trains: each stays until its track has shown GREEN
    tr        = 2'b00;
    served    = 2'b00;
    wait_c[0] = 0;
    wait_c[1] = 0;
    services  = 0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!tr[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            tr[i]     = 1'b1;
            served[i] = 1'b0;
            wait_c[i] = 0;
          end
        end else if (served[i] && ($urandom_range(0, 3) == 0)) begin
          tr[i] = 1'b0;
        end
      end
      train = tr;
      @(posedge clk);
      #1;
      check("inv_road_exclusive",
            {8'd0, !((road != 2'd0) && ((track0 != 2'd0) || (track1 != 2'd0) || gate_down))},
            9'd1);
      check("inv_one_track", {8'd0, !((track0 != 2'd0) && (track1 != 2'd0))}, 9'd1);
      check("inv_grant_onehot", {8'd0, $onehot0(grant)}, 9'd1);
      for (int i = 0; i < 2; i++) begin
        if (tr[i] && !served[i]) begin
          if (((i == 0) ? track0 : track1) == 2'd2) begin
            served[i] = 1'b1;
            services++;
            check("service_latency", {8'd0, (wait_c[i] <= WAIT_BOUND)}, 9'd1);
          end else begin
            wait_c[i]++;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (tr[i] && !served[i]) begin
        check("pending_latency", {8'd0, (wait_c[i] <= WAIT_BOUND)}, 9'd1);
      end
    end
    check("services_seen", {8'd0, (services > 50)}, 9'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
